// File: rtl/rx_bit_unstuff.sv
// rtl/rx_bit_unstuff.sv - USB Rx bit unstuffer and LSB-first byte assembler
// Define USB_RX_STUFF_ERR_EN to turn a 1 in the stuff slot into a sticky stuff violation.
module rx_bit_unstuff #(
  parameter int STUFF_LEN = 6,
  parameter int CNT_BITS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                bit_in,
  input  logic                bit_strobe,
  output logic                bit_out,
  output logic                bit_valid,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  output logic [CNT_BITS-1:0] ones_count,
  output logic                stuff_error,
  output logic                err_active
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STUFF = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [CNT_BITS-1:0] STUFF_MAX = CNT_BITS'(STUFF_LEN);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] ones_q, ones_d, ones_inc;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          sr_q, sr_d;
  logic [7:0]          byte_q, byte_d;
  logic                bit_out_q, bit_out_d;
  logic                bit_valid_q, bit_valid_d;
  logic                byte_valid_q, byte_valid_d;
  logic                stuff_err_q, stuff_err_d;
  logic                err_active_q, err_active_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      byte_q       <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      err_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      byte_q       <= byte_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      byte_valid_q <= byte_valid_d;
      stuff_err_q  <= stuff_err_d;
      err_active_q <= err_active_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    byte_d       = byte_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    stuff_err_d  = 1'b0;
    ones_inc     = ones_q + 1'b1;

    if (clear) begin
      // byte_out deliberately survives a clear; only the partial byte is lost
      state_d   = RUN;
      ones_d    = '0;
      bit_cnt_d = '0;
      sr_d      = '0;
    end else if (bit_strobe) begin
      case (state_q)
        RUN: begin
          bit_out_d   = bit_in;
          bit_valid_d = 1'b1;
          sr_d        = {bit_in, sr_q[7:1]};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_d       = sr_d;
            byte_valid_d = 1'b1;
          end
          if (bit_in) begin
            ones_d = ones_inc;
            if (ones_inc == STUFF_MAX) state_d = STUFF;
          end else begin
            ones_d = '0;
          end
        end
        STUFF: begin
`ifdef USB_RX_STUFF_ERR_EN
          if (bit_in) begin
            stuff_err_d = 1'b1;
            state_d     = ERROR;
          end else begin
            ones_d  = '0;
            state_d = RUN;
          end
`else
          ones_d  = '0;
          state_d = RUN;
`endif
        end
        default: ;
      endcase
    end

    err_active_d = (state_d == ERROR);
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign byte_out    = byte_q;
  assign byte_valid  = byte_valid_q;
  assign ones_count  = ones_q;
  assign stuff_error = stuff_err_q;
  assign err_active  = err_active_q;

endmodule

// File: tb/tb_rx_bit_unstuff.sv
// tb/tb_rx_bit_unstuff.sv - self-checking bench for rx_bit_unstuff
module tb_rx_bit_unstuff;

  localparam int STUFF_LEN = 6;
`ifdef USB_RX_STUFF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       bit_out, bit_valid, byte_valid, stuff_error, err_active;
  logic [7:0] byte_out;
  logic [2:0] ones_count;

  int checks = 0;
  int failures = 0;

  // reference model: run length of 1s, pending-stuff flag, byte under construction
  int   m_ones, m_acc, m_n;
  bit   m_stuff, m_err;
  logic m_bit, m_bv, m_byv, m_serr;
  logic [7:0] m_byte;
  int   byte_pulses;

  rx_bit_unstuff #(.STUFF_LEN(STUFF_LEN), .CNT_BITS(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_strobe(bit_strobe),
    .bit_out(bit_out), .bit_valid(bit_valid), .byte_out(byte_out), .byte_valid(byte_valid),
    .ones_count(ones_count), .stuff_error(stuff_error), .err_active(err_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ones = 0; m_acc = 0; m_n = 0; m_stuff = 0; m_err = 0;
    m_bit = 0; m_bv = 0; m_byv = 0; m_serr = 0; m_byte = 8'h00;
  endtask

  task automatic model_step(input logic s, input logic b, input logic c);
    m_bv = 0; m_byv = 0; m_serr = 0;
    if (c) begin
      m_ones = 0; m_acc = 0; m_n = 0; m_stuff = 0; m_err = 0;
    end else if (s && !m_err) begin
      if (m_stuff) begin
        m_stuff = 0;
        if (b && ERR_EN) begin
          m_err = 1; m_serr = 1;
        end else begin
          m_ones = 0;
        end
      end else begin
        m_bit = b; m_bv = 1;
        m_acc = m_acc + (int'(b) << m_n);
        m_n++;
        if (m_n == 8) begin
          m_byte = 8'(m_acc); m_byv = 1; m_acc = 0; m_n = 0;
        end
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == STUFF_LEN) m_stuff = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bit_valid"}, 32'(bit_valid), 32'(m_bv));
    check({tag, ".byte_valid"}, 32'(byte_valid), 32'(m_byv));
    check({tag, ".byte_out"}, 32'(byte_out), 32'(m_byte));
    check({tag, ".ones_count"}, 32'(ones_count), 32'(m_ones));
    check({tag, ".stuff_error"}, 32'(stuff_error), 32'(m_serr));
    check({tag, ".err_active"}, 32'(err_active), 32'(m_err));
    check({tag, ".bit_out"}, 32'(bit_out), 32'(m_bit));
  endtask

  task automatic step(input string tag, input logic s, input logic b, input logic c);
    @(negedge clk);
    bit_strobe = s; bit_in = b; clear = c;
    @(posedge clk);
    model_step(s, b, c);
    if (byte_valid_next_pending(s, c)) byte_pulses = byte_pulses;
    #1;
    if (byte_valid) byte_pulses++;
    check_all(tag);
  endtask

  function automatic bit byte_valid_next_pending(input logic s, input logic c);
    return s & ~c;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input string tag, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, bits[i], 1'b0);
  endtask

  initial begin
    model_reset();
    byte_pulses = 0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // reset mid-stream, then a byte of zeros
    send("pre_rst", 16'b10111, 5);
    @(negedge clk);
    bit_strobe = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    byte_pulses = 0;
    send("zeros", 16'h0000, 8);
    check("zeros.byte_pulses", 32'(byte_pulses), 32'd1);

    // byte assembly 1,0,1,0,0,1,0,1 -> 0xA5
    send("a5", 16'b1010_0101, 8);
    check("a5.byte_const", 32'(byte_out), 32'h0000_00A5);
    idle(2);

    // stuff removal: six 1s, stuffed 0, then 1,0
    step("clr0", 1'b0, 1'b0, 1'b1);
    send("stuff", 16'b0_1_0_111111, 9);
    check("stuff.ones_after", 32'(ones_count), 32'd0);
    idle(1);

    // seven 1s then a 1
    step("clr1", 1'b0, 1'b0, 1'b1);
    send("viol", 16'b1111_1111, 8);
`ifndef USB_RX_STUFF_ERR_EN
    check("viol.ones_const", 32'(ones_count), 32'd1);
`endif
    send("viol_more", 16'b0101, 4);
    step("clr2", 1'b0, 1'b0, 1'b1);

    // clear together with a strobe after 3 accepted bits
    send("pre_clr", 16'b011, 3);
    step("clr_strobe", 1'b1, 1'b1, 1'b1);
    byte_pulses = 0;
    send("post_clr", 16'b1100_0011, 8);
    check("post_clr.byte_pulses", 32'(byte_pulses), 32'd1);

    // random stream biased toward 1s so stuffing is frequent
    for (int i = 0; i < 3000; i++) begin
      logic s, b, c;
      s = ($urandom_range(0, 4) != 0);
      b = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      step("rand", s, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
